// File: rtl/rbb_wb_arbiter.sv
// Result write-back arbiter: grants one result batch buffer at a time in
// round-robin order, streams its whole batch of lines to the host write
// channel at contiguous line addresses, and counts outstanding writes.
module rbb_wb_arbiter #(
    parameter int NUM_RBB        = 4,
    parameter int LINE_IDX_WIDTH = 8,
    parameter int DATA_WIDTH     = 512,
    parameter int ADDR_WIDTH     = 32,
    parameter int SEQ_WIDTH      = 16,
    parameter int PEND_WIDTH     = 12
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                enable,
    input  logic [ADDR_WIDTH-1:0]               result_base_addr,
    input  logic [NUM_RBB-1:0]                  rbb_req_valid,
    input  logic [NUM_RBB*LINE_IDX_WIDTH-1:0]   rbb_line_idx,
    input  logic [NUM_RBB*DATA_WIDTH-1:0]       rbb_data,
    output logic [NUM_RBB-1:0]                  rbb_req_ack,
    input  logic                                wr_almost_full,
    output logic                                wr_valid,
    output logic [ADDR_WIDTH-1:0]               wr_addr,
    output logic [DATA_WIDTH-1:0]               wr_data,
    input  logic                                wr_resp_valid,
    output logic [NUM_RBB-1:0]                  batch_done,
    output logic [SEQ_WIDTH-1:0]                batch_seq,
    output logic                                drained
);

    localparam int GW   = (NUM_RBB > 1) ? $clog2(NUM_RBB) : 1;
    localparam int PADW = ADDR_WIDTH - SEQ_WIDTH - LINE_IDX_WIDTH;
    localparam logic [LINE_IDX_WIDTH-1:0] LAST_LINE = '1;

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;

    state_e                      state_q, state_d;
    logic [GW-1:0]               rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]               grant_q, grant_d;
    logic [ADDR_WIDTH-1:0]       base_q, base_d;
    logic [SEQ_WIDTH-1:0]        seq_q, seq_d;
    logic [SEQ_WIDTH-1:0]        batch_seq_q, batch_seq_d;
    logic                        wr_valid_q, wr_valid_d;
    logic [ADDR_WIDTH-1:0]       wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]       wr_data_q, wr_data_d;
    logic [NUM_RBB-1:0]          batch_done_q, batch_done_d;
    logic [PEND_WIDTH-1:0]       pend_q, pend_d;

    logic [LINE_IDX_WIDTH-1:0]   line_idx_arr [NUM_RBB];
    logic [DATA_WIDTH-1:0]       data_arr     [NUM_RBB];
    logic                        found;
    logic [GW-1:0]               pick;
    logic [GW:0]                 cand;

    // Unpack the per-channel line index and data buses into arrays
    always_comb begin
        for (int i = 0; i < NUM_RBB; i++) begin
            line_idx_arr[i] = rbb_line_idx[i*LINE_IDX_WIDTH +: LINE_IDX_WIDTH];
            data_arr[i]     = rbb_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Round-robin search starting just after the last granted channel
    always_comb begin
        found = 1'b0;
        pick  = rr_ptr_q;
        cand  = '0;
        for (int k = 1; k <= NUM_RBB; k++) begin
            cand = {1'b0, rr_ptr_q} + (GW+1)'(k);
            if (cand >= (GW+1)'(NUM_RBB)) begin
                cand = cand - (GW+1)'(NUM_RBB);
            end
            if (!found && rbb_req_valid[cand[GW-1:0]]) begin
                found = 1'b1;
                pick  = cand[GW-1:0];
            end
        end
    end

    // Next-state logic: grant in IDLE, stream lines of the granted batch in SEND
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        grant_d      = grant_q;
        base_d       = base_q;
        seq_d        = seq_q;
        batch_seq_d  = batch_seq_q;
        wr_valid_d   = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        batch_done_d = '0;
        rbb_req_ack  = '0;
        case (state_q)
            IDLE: begin
                if (enable && found) begin
                    grant_d = pick;
                    base_d  = result_base_addr;
                    seq_d   = batch_seq_q;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (!wr_almost_full) begin
                    rbb_req_ack[grant_q] = 1'b1;
                    wr_valid_d = 1'b1;
                    wr_addr_d  = base_q + {{PADW{1'b0}}, seq_q, line_idx_arr[grant_q]};
                    wr_data_d  = data_arr[grant_q];
                    if (line_idx_arr[grant_q] == LAST_LINE) begin
                        state_d               = IDLE;
                        rr_ptr_d              = grant_q;
                        batch_seq_d           = batch_seq_q + SEQ_WIDTH'(1);
                        batch_done_d[grant_q] = 1'b1;
                    end
                end
            end
        endcase
    end

    // Outstanding-write counter; a response with nothing pending is dropped
    always_comb begin
        pend_d = pend_q;
        if (wr_valid_q && !(wr_resp_valid && pend_q != '0)) begin
            pend_d = pend_q + PEND_WIDTH'(1);
        end else if (!wr_valid_q && wr_resp_valid && pend_q != '0) begin
            pend_d = pend_q - PEND_WIDTH'(1);
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            rr_ptr_q     <= GW'(NUM_RBB - 1);
            grant_q      <= '0;
            base_q       <= '0;
            seq_q        <= '0;
            batch_seq_q  <= '0;
            wr_valid_q   <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            batch_done_q <= '0;
            pend_q       <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_q      <= grant_d;
            base_q       <= base_d;
            seq_q        <= seq_d;
            batch_seq_q  <= batch_seq_d;
            wr_valid_q   <= wr_valid_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            batch_done_q <= batch_done_d;
            pend_q       <= pend_d;
        end
    end

    assign wr_valid   = wr_valid_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign batch_done = batch_done_q;
    assign batch_seq  = batch_seq_q;
    assign drained    = (state_q == IDLE) && (pend_q == '0);

endmodule

// File: tb/tb_rbb_wb_arbiter.sv
// Testbench for rbb_wb_arbiter: a behavioural buffer model feeds the
// channels, a small arbiter model predicts acks and writes, and expected
// writes go through a scoreboard queue checked against the registered outputs.
module tb_rbb_wb_arbiter;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           enable = 1'b0;
    logic [31:0]    result_base_addr = '0;
    logic [3:0]     rbb_req_valid = '0;
    logic [31:0]    rbb_line_idx = '0;
    logic [2047:0]  rbb_data = '0;
    logic [3:0]     rbb_req_ack;
    logic           wr_almost_full = 1'b0;
    logic           wr_valid;
    logic [31:0]    wr_addr;
    logic [511:0]   wr_data;
    logic           wr_resp_valid = 1'b0;
    logic [3:0]     batch_done;
    logic [15:0]    batch_seq;
    logic           drained;

    rbb_wb_arbiter dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .result_base_addr(result_base_addr),
        .rbb_req_valid(rbb_req_valid), .rbb_line_idx(rbb_line_idx),
        .rbb_data(rbb_data), .rbb_req_ack(rbb_req_ack),
        .wr_almost_full(wr_almost_full), .wr_valid(wr_valid),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_resp_valid(wr_resp_valid), .batch_done(batch_done),
        .batch_seq(batch_seq), .drained(drained)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]  addr;
        logic [511:0] data;
    } wr_t;

    typedef struct {
        logic [3:0]  mask;
        logic [31:0] base;
        logic        en;
        int          afStart;
        int          afLen;
        int          cycles;
        int          expBatches;
        int          expWrites;
        logic [31:0] expFirst;
        logic [31:0] expLast;
        int          expDoneCyc;
    } vec_t;

    int nCompared = 0;
    int nMismatched = 0;

    // Buffer model state
    logic [3:0] bufValid;
    logic [7:0] bufLine [4];
    int         bufBatch [4];

    // Arbiter model state
    int         mState;
    int         mGrant;
    int         mPtr;
    int         mSeq;
    int         mPend;
    logic [31:0] mBase;
    logic       expWrNow;
    logic [3:0] expDone;
    wr_t        sb [$];

    // Per-run statistics
    int          cycNo;
    int          wrCount;
    logic [31:0] firstAddr;
    logic [31:0] lastAddr;
    int          lastDoneCyc;

    vec_t vecs [5];

    function automatic logic [511:0] mkData(input int ch, input int bt, input logic [7:0] ln);
        logic [511:0] d;
        for (int w = 0; w < 16; w++) begin
            d[w*32 +: 32] = {8'(ch), 8'(bt), ln, 8'(w)};
        end
        return d;
    endfunction

    task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cycNo, act, exp);
        end
    endtask

    task automatic updateBufPorts();
        rbb_req_valid = bufValid;
        for (int i = 0; i < 4; i++) begin
            rbb_line_idx[i*8 +: 8]  = bufLine[i];
            rbb_data[i*512 +: 512]  = mkData(i, bufBatch[i], bufLine[i]);
        end
    endtask

    task automatic loadBuffers(input logic [3:0] mask);
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                bufValid[i] = 1'b1;
                bufLine[i]  = 8'd0;
            end
        end
        updateBufPorts();
        cycNo       = 0;
        wrCount     = 0;
        firstAddr   = '0;
        lastAddr    = '0;
        lastDoneCyc = -1;
    endtask

    task automatic doReset();
        reset_n        = 1'b0;
        enable         = 1'b0;
        wr_almost_full = 1'b0;
        wr_resp_valid  = 1'b0;
        bufValid       = '0;
        for (int i = 0; i < 4; i++) begin
            bufLine[i]  = 8'd0;
            bufBatch[i] = 0;
        end
        updateBufPorts();
        @(posedge clk);
        #1;
        checkOutput("rst_ack", rbb_req_ack, '0);
        checkOutput("rst_wr_valid", wr_valid, '0);
        checkOutput("rst_wr_addr", wr_addr, '0);
        checkOutput("rst_wr_data", wr_data, '0);
        checkOutput("rst_batch_done", batch_done, '0);
        checkOutput("rst_batch_seq", batch_seq, '0);
        checkOutput("rst_drained", drained, 1'b1);
        reset_n  = 1'b1;
        mState   = 0;
        mGrant   = 0;
        mPtr     = 3;
        mSeq     = 0;
        mPend    = 0;
        mBase    = '0;
        expWrNow = 1'b0;
        expDone  = '0;
        sb.delete();
    endtask

    // One clock cycle: drive inputs, predict and check the ack, advance the
    // models across the edge, then check the registered outputs.
    task automatic applyStimulus(input logic af, input logic en, input logic resp);
        logic [3:0]  expAck;
        logic [3:0]  ackSeen;
        logic [3:0]  doneNext;
        logic        pushed;
        logic [7:0]  ln;
        int          nState, nGrant, nPtr, nSeq, nPend;
        logic [31:0] nBase;
        wr_t         e;
        bit          got;

        wr_almost_full = af;
        enable         = en;
        wr_resp_valid  = resp;
        #1;
        expAck   = '0;
        doneNext = '0;
        pushed   = 1'b0;
        got      = 1'b0;
        nState = mState; nGrant = mGrant; nPtr = mPtr; nSeq = mSeq; nBase = mBase;
        if (mState == 1 && !af) begin
            expAck[mGrant] = 1'b1;
            ln = bufLine[mGrant];
            e.addr = mBase + {8'h00, 16'(mSeq), ln};
            e.data = mkData(mGrant, bufBatch[mGrant], ln);
            sb.push_back(e);
            pushed = 1'b1;
            if (ln == 8'hFF) begin
                nState   = 0;
                nPtr     = mGrant;
                nSeq     = mSeq + 1;
                doneNext[mGrant] = 1'b1;
            end
        end else if (mState == 0 && en && bufValid != 4'd0) begin
            for (int k = 1; k <= 4; k++) begin
                int c;
                c = (mPtr + k) % 4;
                if (!got && bufValid[c]) begin
                    got    = 1'b1;
                    nGrant = c;
                end
            end
            nBase  = result_base_addr;
            nState = 1;
        end
        nPend = mPend;
        if (expWrNow && !(resp && mPend != 0)) nPend = mPend + 1;
        else if (!expWrNow && resp && mPend != 0) nPend = mPend - 1;

        ackSeen = rbb_req_ack;
        checkOutput("ack", ackSeen, expAck);

        @(posedge clk);
        #1;
        cycNo++;
        for (int i = 0; i < 4; i++) begin
            if (ackSeen[i] && bufValid[i]) begin
                if (bufLine[i] == 8'hFF) begin
                    bufValid[i] = 1'b0;
                    bufLine[i]  = 8'd0;
                    bufBatch[i] = bufBatch[i] + 1;
                end else begin
                    bufLine[i] = bufLine[i] + 8'd1;
                end
            end
        end
        updateBufPorts();
        mState = nState; mGrant = nGrant; mPtr = nPtr; mSeq = nSeq;
        mBase = nBase; mPend = nPend;
        expWrNow = pushed;
        expDone  = doneNext;

        checkOutput("wr_valid", wr_valid, expWrNow);
        if (wr_valid) begin
            if (wrCount == 0) firstAddr = wr_addr;
            lastAddr = wr_addr;
            wrCount++;
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (wr_valid) begin
                checkOutput("wr_addr", wr_addr, e.addr);
                checkOutput("wr_data", wr_data, e.data);
            end
        end
        if (batch_done != 4'd0) lastDoneCyc = cycNo;
        checkOutput("batch_done", batch_done, expDone);
        checkOutput("batch_seq", batch_seq, 16'(mSeq));
        checkOutput("drained", drained, (mState == 0) && (mPend == 0));
    endtask

    initial begin
        //            mask     base          en   afS afL cyc  bat wr   first         last          doneCyc
        vecs[0] = '{4'b0001, 32'h0000_1000, 1'b1, 0,  0, 262, 1, 256, 32'h0000_1000, 32'h0000_10FF, 257};
        vecs[1] = '{4'b0101, 32'h0000_1000, 1'b1, 0,  0, 520, 2, 512, 32'h0000_1000, 32'h0000_11FF, 514};
        vecs[2] = '{4'b0001, 32'h0000_1000, 1'b1, 50, 5, 270, 1, 256, 32'h0000_1000, 32'h0000_10FF, 262};
        vecs[3] = '{4'b0001, 32'hFFFF_FF80, 1'b1, 0,  0, 262, 1, 256, 32'hFFFF_FF80, 32'h0000_007F, 257};
        vecs[4] = '{4'b0010, 32'h0000_1000, 1'b0, 0,  0, 20,  0, 0,   32'h0000_0000, 32'h0000_0000, -1};

        for (int v = 0; v < 5; v++) begin
            doReset();
            result_base_addr = vecs[v].base;
            loadBuffers(vecs[v].mask);
            for (int k = 0; k < vecs[v].cycles; k++) begin
                applyStimulus((k >= vecs[v].afStart) && (k < vecs[v].afStart + vecs[v].afLen),
                              vecs[v].en, 1'b0);
            end
            checkOutput($sformatf("vec%0d_batches", v), batch_seq, 16'(vecs[v].expBatches));
            checkOutput($sformatf("vec%0d_writes", v), wrCount, vecs[v].expWrites);
            checkOutput($sformatf("vec%0d_first_addr", v), firstAddr, vecs[v].expFirst);
            checkOutput($sformatf("vec%0d_last_addr", v), lastAddr, vecs[v].expLast);
            checkOutput($sformatf("vec%0d_done_cycle", v), lastDoneCyc, vecs[v].expDoneCyc);
        end

        // Pending counter: 256 writes, then responses drain it one by one
        doReset();
        result_base_addr = 32'h0000_1000;
        loadBuffers(4'b0001);
        for (int k = 0; k < 262; k++) applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("pend_after_batch_drained", drained, 1'b0);
        for (int k = 0; k < 255; k++) applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("pend_255_resp_drained", drained, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("pend_256_resp_drained", drained, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("pend_underflow_drained", drained, 1'b1);

        // Second batch with a response alongside every write after the first
        loadBuffers(4'b0001);
        for (int k = 0; k < 262; k++) applyStimulus(1'b0, 1'b1, (mPend != 0) && expWrNow);
        checkOutput("simul_batch_seq", batch_seq, 16'd2);
        checkOutput("simul_last_addr", lastAddr, 32'h0000_11FF);
        checkOutput("simul_one_left_drained", drained, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("simul_final_drained", drained, 1'b1);

        // Enable low holds off channel 1; then grant and reset mid-batch
        doReset();
        result_base_addr = 32'h0000_2000;
        loadBuffers(4'b0010);
        for (int k = 0; k < 10; k++) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("en_low_no_write", wrCount, 0);
        for (int k = 0; k < 100; k++) applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("en_high_first_addr", firstAddr, 32'h0000_2000);
        checkOutput("en_high_mid_drained", drained, 1'b0);
        doReset();
        for (int k = 0; k < 5; k++) applyStimulus(1'b0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/rbb_wb_arbiter.md
# rbb_wb_arbiter

Result write-back arbiter. It sits directly downstream of the result batch buffers (one per PE array). It grants one buffer at a time in round-robin order and drains that buffer's full batch of 512-bit lines into the host write channel with contiguous line addresses. It also tracks outstanding write responses so software can tell when all results have landed in memory.

## Interface
- NUM_RBB, 4: number of result batch buffer channels.
- LINE_IDX_WIDTH, 8: line index width; lines per batch = 2^LINE_IDX_WIDTH.
- DATA_WIDTH, 512: line width.
- ADDR_WIDTH, 32: host line address width (64-byte line units).
- SEQ_WIDTH, 16: batch sequence counter width.
- PEND_WIDTH, 12: outstanding-write counter width.

Ports:
- clk  in  1  core clock.
- reset_n  in  1  reset; synchronous, active-low.
- enable  in  1  allow new grants.
- result_base_addr  in  ADDR_WIDTH  result region base line address; sampled at grant.
- rbb_req_valid  in  NUM_RBB  channel i holds a complete batch.
- rbb_line_idx  in  NUM_RBB*LINE_IDX_WIDTH  current line index per channel, packed, channel 0 in LSBs.
- rbb_data  in  NUM_RBB*DATA_WIDTH  current line data per channel, packed.
- rbb_req_ack  out  NUM_RBB  line consumed; combinational, one-hot or zero.
- wr_almost_full  in  1  host write channel backpressure.
- wr_valid  out  1  write request.
- wr_addr  out  ADDR_WIDTH  write line address.
- wr_data  out  DATA_WIDTH  write data.
- wr_resp_valid  in  1  one write completion.
- batch_done  out  NUM_RBB  one-cycle pulse when channel i's last line is issued.
- batch_seq  out  SEQ_WIDTH  number of batches fully issued, mod 2^SEQ_WIDTH.
- drained  out  1  state IDLE and no writes outstanding.

## Operation
- Channel contract:
  - While rbb_req_valid[i] is high, rbb_line_idx/rbb_data for channel i are valid.
  - After an ack at cycle t, the next line is valid at t+1.
  - Lines arrive 0..2^LINE_IDX_WIDTH-1 in order.
- State machine, two states:
  - IDLE:
    - If enable and any rbb_req_valid, select a channel by round-robin search from rr_ptr+1 upward, wrapping modulo NUM_RBB.
    - Latch grant, latch base = result_base_addr, latch seq = batch_seq; go to SEND.
    - No acks are issued in IDLE.
  - SEND:
    - Each cycle with !wr_almost_full, assert rbb_req_ack[grant] and capture the granted line into the output registers.
    - If the captured rbb_line_idx == 2^LINE_IDX_WIDTH-1: go to IDLE, rr_ptr <= grant, batch_seq++, pulse batch_done[grant] in the next cycle.
    - With wr_almost_full high: no ack, no write, hold state.
    - enable low does not abort SEND.
- Address: wr_addr = base + ({seq, line_idx} zero-extended to ADDR_WIDTH), truncated mod 2^ADDR_WIDTH. Wrap is silent.
- Pending counter:
  - +1 per wr_valid, -1 per wr_resp_valid; simultaneous events leave it unchanged.
  - A response with pending == 0 is ignored (no underflow).
  - Overflow is not reachable given backpressure; not checked.
- drained = (state == IDLE) && pending == 0.

## Timing
- Reset values:
  - state IDLE, rr_ptr = NUM_RBB-1 (channel 0 searched first).
  - wr_valid 0, wr_addr 0, wr_data 0, batch_done 0, batch_seq 0, pending 0, drained 1.
  - rbb_req_ack 0 (state IDLE).
- Reset mid-batch discards the batch; buffers share reset_n.
- Latency:
  - rbb_req_valid seen in IDLE at cycle 0: SEND from cycle 1, first ack cycle 1, first wr_valid cycle 2.
  - With no backpressure, 256 lines: acks at cycles 1..256, wr_valid at 2..257, batch_done pulse at 257, IDLE at 257.
  - Next grant is at cycle 257 with SEND from 258, so there is one idle cycle between batches.
- wr_valid, wr_addr, wr_data are registered, issued one cycle after the corresponding ack.
- wr_almost_full sampled in cycle t suppresses the ack at t, and therefore wr_valid at t+1.

## Test plan
- Single channel, base 0x1000, no backpressure, 256 lines → wr_addr 0x1000..0x10FF on consecutive cycles, data matches line order, batch_done[0] at cycle 257, batch_seq 1.
- Channels 0 and 2 both valid at reset → channel 0 drained first, then channel 2 at addresses 0x1100..0x11FF; batch_done[0] then batch_done[2].
- wr_almost_full high for 5 cycles mid-batch → no ack or write for those cycles, no line lost or duplicated, total 256 writes.
- 256 writes followed by 255 responses → drained 0; 256th response → drained 1; simultaneous wr_valid and wr_resp_valid → pending unchanged.
- Base 0xFFFFFF80 with 256 lines → addresses wrap past 0xFFFFFFFF to 0x0..0x7F.
- enable low while channel 1 valid → no grant; reset_n low mid-batch → all outputs return to reset values the next cycle.
